// File: rtl/ae_adc_framer.sv
// Multi-channel ADC framer: settles, optionally arms on a channel-0 threshold, decimates,
// then emits one tagged 32-bit word per channel into a write-when-not-full FIFO.
module ae_adc_framer #(
    parameter int unsigned ADC_W   = 14,
    parameter int unsigned NCH     = 2,
    parameter int unsigned SETTLE  = 5,
    parameter logic [15:0] TAG     = 16'h5354,
    parameter int unsigned DECIM_W = 8
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   ENABLE,
    input  logic                   SAMPLE_STB,
    input  logic [NCH*ADC_W-1:0]   ADC_DATA,
    input  logic [DECIM_W-1:0]     DECIM,
    input  logic                   THRESH_EN,
    input  logic [ADC_W-1:0]       THRESH,
    input  logic                   FIFO_FULL,
    output logic                   FIFO_WREN,
    output logic [31:0]            FIFO_DATA,
    output logic [15:0]            OVERFLOW_CNT,
    output logic                   BUSY
);

    if (ADC_W < 1 || ADC_W > 16 || NCH < 1 || NCH > 16) begin : g_param_check
        $error("ae_adc_framer: ADC_W must be 1..16 and NCH must be 1..16");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ARMED, S_RUN} state_t;

    localparam logic [3:0]  LAST_IDX   = 4'(NCH - 1);
    localparam logic [15:0] SETTLE_END = 16'(SETTLE - 1);

    state_t               state;
    state_t               after_settle;
    logic [15:0]          settle_cnt;
    logic [DECIM_W-1:0]   decim_cnt;
    logic [ADC_W-1:0]     snap [NCH];
    logic [3:0]           idx;
    logic [ADC_W-1:0]     cur_sample;
    logic                 wr;
    logic                 last_wr;
    logic                 keep;
    logic                 accept;

    assign after_settle = THRESH_EN ? S_ARMED : S_RUN;
    assign wr           = BUSY & ~FIFO_FULL;
    assign last_wr      = wr && (idx == LAST_IDX);
    // A kept strobe is taken when idle or when it lands on the burst's final write.
    assign accept       = keep & (~BUSY | last_wr);

    always_comb begin
        keep = 1'b0;
        if (SAMPLE_STB && ENABLE) begin
            case (state)
                S_ARMED: keep = (ADC_DATA[ADC_W-1:0] >= THRESH);
                S_RUN:   keep = (decim_cnt == '0);
                default: keep = 1'b0;
            endcase
        end
    end

    always_comb begin
        cur_sample = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (idx == 4'(k)) cur_sample = snap[k];
        end
    end

    assign FIFO_WREN = wr;
    assign FIFO_DATA = BUSY ? {TAG[15:4], idx, 16'(cur_sample)} : '0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= S_IDLE;
            settle_cnt   <= '0;
            decim_cnt    <= '0;
            idx          <= '0;
            BUSY         <= 1'b0;
            OVERFLOW_CNT <= '0;
            for (int unsigned k = 0; k < NCH; k++) snap[k] <= '0;
        end else begin
            if (wr) begin
                if (idx == LAST_IDX) begin
                    BUSY <= 1'b0;
                    idx  <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end

            if (keep) begin
                if (accept) begin
                    for (int unsigned k = 0; k < NCH; k++) snap[k] <= ADC_DATA[k*ADC_W +: ADC_W];
                    BUSY <= 1'b1;
                    idx  <= '0;
                end else if (OVERFLOW_CNT != '1) begin
                    OVERFLOW_CNT <= OVERFLOW_CNT + 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (ENABLE) begin
                        OVERFLOW_CNT <= '0;
                        settle_cnt   <= '0;
                        decim_cnt    <= '0;
                        state        <= (SETTLE == 0) ? after_settle : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (!ENABLE) begin
                        state <= S_IDLE;
                    end else if (SAMPLE_STB) begin
                        if (settle_cnt == SETTLE_END) begin
                            state     <= after_settle;
                            decim_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (!ENABLE) begin
                        state <= S_IDLE;
                    end else if (keep) begin
                        state     <= S_RUN;
                        decim_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (!ENABLE) begin
                        if (!BUSY) state <= S_IDLE;
                    end else if (SAMPLE_STB) begin
                        decim_cnt <= (decim_cnt == DECIM) ? '0 : decim_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
